// File: rtl/poly_mod_sub.sv
// Streaming coefficient-wise modular subtractor: diff = (in1 - in2) mod Q over one
// N-coefficient polynomial. Two-stage pipeline with a frame FSM and valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for start; pipeline empty
// RUN   | accepting pairs and emitting differences
// DONE  | one-cycle done pulse after the last output
module poly_mod_sub #(
    parameter int DATA_WID = 12,
    parameter int Q        = 3329,
    parameter int N        = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_WID-1:0] in1,
    input  logic [DATA_WID-1:0] in2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_WID-1:0] diff,
    output logic                out_last,
    output logic                busy,
    output logic                done
);
    localparam int CW = $clog2(N + 1);
    localparam logic [DATA_WID-1:0] Q_W    = DATA_WID'(Q);
    localparam logic [CW-1:0]       N_C    = CW'(N);
    localparam logic [CW-1:0]       LAST_C = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       in_cnt, out_cnt;
    logic                s1_valid;
    logic [DATA_WID-1:0] s1_a, s1_b;
    logic                adv, accept, out_hs;
    logic [DATA_WID:0]   t;
    logic [DATA_WID-1:0] diff_nxt;

    // Inputs are below 2Q, so a single conditional subtract fully reduces them.
    function automatic logic [DATA_WID-1:0] reduce(input logic [DATA_WID-1:0] a);
        return (a >= Q_W) ? a - Q_W : a;
    endfunction

    assign t        = {1'b0, s1_a} - {1'b0, s1_b};
    assign diff_nxt = t[DATA_WID] ? t[DATA_WID-1:0] + Q_W : t[DATA_WID-1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (out_hs && out_cnt == LAST_C) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        adv      = !out_valid || out_ready;
        in_ready = (state == RUN) && (in_cnt < N_C) && adv;
        accept   = in_valid && in_ready;
        out_hs   = out_valid && out_ready;
        out_last = out_valid && (out_cnt == LAST_C);
        busy     = (state != IDLE);
        done     = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (state == IDLE && start) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (accept) in_cnt  <= in_cnt + 1'b1;
            if (out_hs) out_cnt <= out_cnt + 1'b1;
        end
    end

    // Both stages advance together on adv so a stall freezes the whole pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_a <= reduce(in1);
                s1_b <= reduce(in2);
            end
            out_valid <= s1_valid;
            if (s1_valid) diff <= diff_nxt;
        end
    end
endmodule
